outlier_detector: RTL and testbench

Parametrised streaming outlier detector for Q(DATA_W−FRAC_W).FRAC_W signed samples. Each accepted sample is compared against the mean of a sliding window of the last 2^DEPTH_LOG2 accepted samples. It is flagged when its absolute deviation exceeds K_MULT times an exponentially-averaged mean absolute deviation (MAD). It sits between the sample source, which strobes `new_number`, and the host logic that consumes `flag`/`x_out`. Compared with the fixed single-window detector, it adds configurable width, depth, sensitivity and outlier exclusion.

---
 rtl/outlier_pkg.sv | 26 ++
 rtl/outlier_detector_if.sv | 32 +++
 rtl/od_window_buf.sv | 45 ++++
 rtl/outlier_detector.sv | 161 ++++++++++++++++
 tb/tb_outlier_detector.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/outlier_pkg.sv
// outlier_pkg: shared types and width helpers for the outlier detector.
//   od_state_t  - sequencing states (IDLE, EVAL, COMMIT)
//   depth_of    - window depth from its log2
//   sum_width   - width of the running window sum (never overflows)
//   thr_width   - width of the K_MULT * mad threshold
package outlier_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2
  } od_state_t;

  function automatic int depth_of(input int depth_log2);
    return 1 << depth_log2;
  endfunction

  function automatic int sum_width(input int data_w, input int depth_log2);
    return data_w + depth_log2;
  endfunction

  function automatic int thr_width(input int data_w);
    return data_w + 5;
  endfunction

endpackage

// File: rtl/outlier_detector_if.sv
// outlier_detector_if: sample stream in, verdict stream out.
//   new_number - level strobe from the sample source (rising edge = new sample)
//   x_in       - signed sample, stable while new_number is high
//   x_out      - last accepted sample
//   mean       - window mean after the last update
//   flag       - outlier verdict for x_out
//   out_valid  - one-cycle pulse when x_out/mean/flag/warm update
//   warm       - window has been filled once
//   busy       - detector is evaluating/committing a sample
// master = source/host side, slave = detector side.
interface outlier_detector_if #(
  parameter int DATA_W = 32
);
  logic              new_number;
  logic [DATA_W-1:0] x_in;
  logic [DATA_W-1:0] x_out;
  logic [DATA_W-1:0] mean;
  logic              flag;
  logic              out_valid;
  logic              warm;
  logic              busy;

  modport master (
    output new_number, x_in,
    input  x_out, mean, flag, out_valid, warm, busy
  );

  modport slave (
    input  new_number, x_in,
    output x_out, mean, flag, out_valid, warm, busy
  );
endinterface

// File: rtl/od_window_buf.sv
// od_window_buf: circular window of the last 2^DEPTH_LOG2 accepted samples.
//   clk, reset - clock, asynchronous active-low clear (entries clear to zero)
//   wr_en      - append wr_data, overwriting the oldest entry
//   wr_data    - sample to append
//   rd_oldest  - combinational read of the oldest entry (the one wr_en replaces)
//   full       - the window has been filled at least once since reset
module od_window_buf
  import outlier_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_oldest,
  output logic              full
);
  localparam int DEPTH = depth_of(DEPTH_LOG2);
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [CNT_W-1:0]      count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
      wr_ptr_q        <= wr_ptr_q + 1'b1;
      if (count_q != DEPTH_CNT) count_q <= count_q + 1'b1;
    end
  end

  // The write slot is always the oldest entry once the pointer has wrapped;
  // before that it holds the zero padding that the mean is computed over.
  assign rd_oldest = mem_q[wr_ptr_q];
  assign full      = (count_q == DEPTH_CNT);

endmodule

// File: rtl/outlier_detector.sv
// outlier_detector: streaming outlier detector over a sliding-window mean.
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - outlier_detector_if.slave (sample strobe in, verdict/mean out)
// A sample is flagged when |x - mean| exceeds K_MULT * mad, where mad is an
// exponentially averaged absolute deviation. With EXCLUDE set, flagged
// samples neither enter the window nor move mad.
//
// state  | meaning
// IDLE   | waiting for a rising edge on new_number
// EVAL   | deviation, threshold and verdict computed from the captured sample
// COMMIT | window/sum/mad updated (unless excluded), outputs registered
module outlier_detector
  import outlier_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FRAC_W      = 16,
  parameter int DEPTH_LOG2  = 4,
  parameter int ALPHA_SHIFT = 3,
  parameter int K_MULT      = 3,
  parameter int EXCLUDE     = 1
) (
  input logic                clk,
  input logic                reset,
  outlier_detector_if.slave  bus
);
  localparam int SUM_W = sum_width(DATA_W, DEPTH_LOG2);
  localparam int THR_W = thr_width(DATA_W);

  generate
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 6) begin : g_bad_depth
      $error("outlier_detector: DEPTH_LOG2 must be 1..6");
    end
    if (K_MULT < 1 || K_MULT > 15) begin : g_bad_k
      $error("outlier_detector: K_MULT must be 1..15");
    end
    if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac
      $error("outlier_detector: FRAC_W must be 0..DATA_W-1");
    end
  endgenerate

  od_state_t state_q, state_d;

  logic                     prev_q;
  logic signed [DATA_W-1:0] x_q, oldest_q, x_out_q, mean_q;
  logic [DATA_W-1:0]        rd_oldest;
  logic [DATA_W:0]          absdev_q, mad_q;
  logic                     flag_n_q, flag_q, out_valid_q;
  logic signed [SUM_W-1:0]  sum_q, sum_new;
  logic                     full, accept, upd, wr_en, busy_c;

  logic signed [DATA_W:0]   dev;
  logic [DATA_W:0]          absdev;
  logic [THR_W-1:0]         thr;
  logic                     flag_c;
  logic signed [DATA_W+1:0] mad_diff, mad_sum;
  logic [DATA_W:0]          mad_new;
  logic signed [DATA_W-1:0] mean_new;

  // prev_q resets to 1 so a strobe already high at reset release is not an edge.
  assign accept = (state_q == IDLE) && bus.new_number && !prev_q;
  assign upd    = !(flag_n_q && (EXCLUDE != 0));

  od_window_buf #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_window (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (x_q),
    .rd_oldest (rd_oldest),
    .full      (full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL: begin
        busy_c  = 1'b1;
        state_d = COMMIT;
      end
      COMMIT: begin
        busy_c  = 1'b1;
        wr_en   = upd;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // One extra bit holds any difference of two DATA_W samples exactly.
    dev    = $signed({x_q[DATA_W-1], x_q}) - $signed({mean_q[DATA_W-1], mean_q});
    absdev = dev[DATA_W] ? $unsigned(-dev) : $unsigned(dev);
    thr    = THR_W'(mad_q) * THR_W'(K_MULT);
    flag_c = full && (THR_W'(absdev) > thr);

    sum_new = sum_q;
    if (upd) sum_new = sum_q + SUM_W'(x_q) - SUM_W'(oldest_q);
    mean_new = DATA_W'(sum_new >>> DEPTH_LOG2);

    // Signed difference so the average can fall; floor shift, then clamp at 0.
    mad_diff = $signed({1'b0, absdev_q}) - $signed({1'b0, mad_q});
    mad_sum  = $signed({1'b0, mad_q}) + (mad_diff >>> ALPHA_SHIFT);
    mad_new  = mad_sum[DATA_W+1] ? '0 : mad_sum[DATA_W:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q      <= 1'b1;
      x_q         <= '0;
      oldest_q    <= '0;
      absdev_q    <= '0;
      flag_n_q    <= 1'b0;
      sum_q       <= '0;
      mad_q       <= '0;
      x_out_q     <= '0;
      mean_q      <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      prev_q      <= bus.new_number;
      out_valid_q <= 1'b0;
      if (accept) begin
        x_q      <= bus.x_in;
        oldest_q <= rd_oldest;
      end
      if (state_q == EVAL) begin
        absdev_q <= absdev;
        flag_n_q <= flag_c;
      end
      if (state_q == COMMIT) begin
        if (upd) begin
          sum_q <= sum_new;
          mad_q <= mad_new;
        end
        x_out_q     <= x_q;
        flag_q      <= flag_n_q;
        mean_q      <= mean_new;
        out_valid_q <= 1'b1;
      end
    end
  end

  assign bus.x_out     = x_out_q;
  assign bus.mean      = mean_q;
  assign bus.flag      = flag_q;
  assign bus.out_valid = out_valid_q;
  assign bus.warm      = full;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_outlier_detector.sv
// tb_outlier_detector: two detectors (EXCLUDE=1 and EXCLUDE=0) driven by the
// same strobe/sample stream and checked against a queue-level reference model.
module tb_outlier_detector;
  localparam int     DW    = 32;
  localparam int     DL2   = 2;
  localparam int     DEPTH = 4;
  localparam int     AS    = 2;
  localparam longint KM    = 3;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          new_number = 1'b0;
  logic [DW-1:0] x_in       = '0;

  always #5 clk = ~clk;

  outlier_detector_if #(.DATA_W(DW)) bus_a ();
  outlier_detector_if #(.DATA_W(DW)) bus_b ();

  assign bus_a.new_number = new_number;
  assign bus_a.x_in       = x_in;
  assign bus_b.new_number = new_number;
  assign bus_b.x_in       = x_in;

  outlier_detector #(
    .DATA_W(DW), .FRAC_W(16), .DEPTH_LOG2(DL2), .ALPHA_SHIFT(AS), .K_MULT(3), .EXCLUDE(1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  outlier_detector #(
    .DATA_W(DW), .FRAC_W(16), .DEPTH_LOG2(DL2), .ALPHA_SHIFT(AS), .K_MULT(3), .EXCLUDE(0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  logic          ov     [2];
  logic          busy_w [2];
  logic          flag_w [2];
  logic          warm_w [2];
  logic [DW-1:0] mean_w [2];
  logic [DW-1:0] xo_w   [2];

  assign ov[0] = bus_a.out_valid;  assign ov[1] = bus_b.out_valid;
  assign busy_w[0] = bus_a.busy;   assign busy_w[1] = bus_b.busy;
  assign flag_w[0] = bus_a.flag;   assign flag_w[1] = bus_b.flag;
  assign warm_w[0] = bus_a.warm;   assign warm_w[1] = bus_b.warm;
  assign mean_w[0] = bus_a.mean;   assign mean_w[1] = bus_b.mean;
  assign xo_w[0] = bus_a.x_out;    assign xo_w[1] = bus_b.x_out;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  // Reference model: window kept as a shift list (index 0 oldest), sum
  // recomputed from scratch every sample, floor division done explicitly.
  longint win   [2][DEPTH];
  int     cnt   [2];
  longint mad   [2];
  longint mmean [2];

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) win[k][i] = 0;
      cnt[k]   = 0;
      mad[k]   = 0;
      mmean[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input longint x, input bit excl,
                            output bit f, output longint m, output bit w);
    longint ad, s;
    ad = x - mmean[k];
    if (ad < 0) ad = -ad;
    f = (cnt[k] == DEPTH) && (ad > KM * mad[k]);
    if (!(f && excl)) begin
      for (int i = 0; i < DEPTH - 1; i++) win[k][i] = win[k][i+1];
      win[k][DEPTH-1] = x;
      if (cnt[k] < DEPTH) cnt[k]++;
      mad[k] = mad[k] + floor_div(ad - mad[k], longint'(1) << AS);
      if (mad[k] < 0) mad[k] = 0;
    end
    s = 0;
    for (int i = 0; i < DEPTH; i++) s += win[k][i];
    mmean[k] = floor_div(s, DEPTH);
    m = mmean[k];
    w = (cnt[k] == DEPTH);
  endtask

  longint obs_mean [2];
  longint obs_xo   [2];
  logic   obs_flag [2];
  logic   obs_warm [2];

  // One sample: strobe high 20 cycles, low 30, every cycle sampled at negedge.
  task automatic send(input logic [DW-1:0] x);
    bit     ef [2];
    bit     ew [2];
    longint em [2];
    longint pm [2];
    int     lat [2];
    int     nov [2];
    int     nbusy [2];
    for (int k = 0; k < 2; k++) begin
      pm[k] = mmean[k]; lat[k] = -1; nov[k] = 0; nbusy[k] = 0;
      obs_mean[k] = 0; obs_xo[k] = 0; obs_flag[k] = 1'b0; obs_warm[k] = 1'b0;
      model_step(k, sx(x), (k == 0), ef[k], em[k], ew[k]);
    end
    @(negedge clk);
    x_in = x;
    new_number = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (c == 2) chk($sformatf("hold_mean[%0d]", k), sx(mean_w[k]), pm[k]);
        if (busy_w[k]) nbusy[k]++;
        if (ov[k]) begin
          nov[k]++;
          if (lat[k] < 0) begin
            lat[k] = c;
            obs_mean[k] = sx(mean_w[k]);
            obs_xo[k]   = sx(xo_w[k]);
            obs_flag[k] = flag_w[k];
            obs_warm[k] = warm_w[k];
          end
        end
      end
      if (c == 20) new_number = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("latency[%0d]", k), lat[k], 3);
      chk($sformatf("ov_pulses[%0d]", k), nov[k], 1);
      chk($sformatf("busy_cycles[%0d]", k), nbusy[k], 2);
      chk($sformatf("x_out[%0d]", k), obs_xo[k], sx(x));
      chk($sformatf("flag[%0d]", k), obs_flag[k], ef[k]);
      chk($sformatf("mean[%0d]", k), obs_mean[k], em[k]);
      chk($sformatf("warm[%0d]", k), obs_warm[k], ew[k]);
    end
  endtask

  // nn_at_release raises new_number on the same edge reset deasserts.
  task automatic do_reset(input bit nn_at_release);
    int nov;
    @(negedge clk);
    reset = 1'b0;
    new_number = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b1;
    new_number = nn_at_release;
    if (nn_at_release) begin
      nov = 0;
      repeat (20) begin
        @(negedge clk);
        nov += int'(ov[0]) + int'(ov[1]);
      end
      chk("no_accept_at_release", nov, 0);
      new_number = 1'b0;
      repeat (30) @(negedge clk);
    end else begin
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nov;
    int unsigned r;
    logic [DW-1:0] v;

    // 1: reset state
    do_reset(1'b0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_x_out[%0d]", k), xo_w[k], 0);
      chk($sformatf("rst_mean[%0d]", k), mean_w[k], 0);
      chk($sformatf("rst_flag[%0d]", k), flag_w[k], 0);
      chk($sformatf("rst_ov[%0d]", k), ov[k], 0);
      chk($sformatf("rst_warm[%0d]", k), warm_w[k], 0);
      chk($sformatf("rst_busy[%0d]", k), busy_w[k], 0);
    end

    // 2: warm-up with 1.0
    send(32'h0001_0000);
    chk("t2_mean1", obs_mean[0], sx(32'h0000_4000));
    chk("t2_warm1", obs_warm[0], 0);
    send(32'h0001_0000);
    chk("t2_mean2", obs_mean[0], sx(32'h0000_8000));
    send(32'h0001_0000);
    chk("t2_mean3", obs_mean[0], sx(32'h0000_C000));
    chk("t2_warm3", obs_warm[0], 0);
    send(32'h0001_0000);
    chk("t2_mean4", obs_mean[0], sx(32'h0001_0000));
    chk("t2_warm4", obs_warm[0], 1);
    chk("t2_flag4", obs_flag[0], 0);

    // 3: spike excluded from the window, then normal sample
    send(32'h000A_0000);
    chk("t3_spike_flag", obs_flag[0], 1);
    chk("t3_spike_mean", obs_mean[0], sx(32'h0001_0000));
    send(32'h0001_0000);
    chk("t3_after_flag", obs_flag[0], 0);
    chk("t3_after_mean", obs_mean[0], sx(32'h0001_0000));

    // 4: negative window, mad decays to zero, then small deviation
    do_reset(1'b1);
    repeat (4) send(32'hFFFE_0000);
    chk("t4_mean_a", obs_mean[0], sx(32'hFFFE_0000));
    chk("t4_mean_b", obs_mean[1], sx(32'hFFFE_0000));
    repeat (45) send(32'hFFFE_0000);
    send(32'hFFFE_4000);
    chk("t4_flag_a", obs_flag[0], 1);
    chk("t4_flag_b", obs_flag[1], 1);
    chk("t4_mean_a_kept", obs_mean[0], sx(32'hFFFE_0000));
    chk("t4_mean_b_upd", obs_mean[1], sx(32'hFFFE_1000));

    // 5: full-scale extremes
    do_reset(1'b0);
    repeat (4) send(32'h7FFF_FFFF);
    chk("t5_mean_max", obs_mean[0], sx(32'h7FFF_FFFF));
    send(32'h8000_0000);
    chk("t5_flag_a", obs_flag[0], 1);
    chk("t5_flag_b", obs_flag[1], 1);

    // 6: reset during EVAL discards the in-flight sample
    send(32'h0002_0000);
    @(negedge clk);
    x_in = 32'h0003_0000;
    new_number = 1'b1;
    @(negedge clk);
    chk("t6_busy_eval", busy_w[0], 1);
    reset = 1'b0;
    #1;
    chk("t6_busy_rst", busy_w[0], 0);
    chk("t6_warm_rst", warm_w[0], 0);
    new_number = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
    nov = 0;
    repeat (10) begin
      @(negedge clk);
      nov += int'(ov[0]) + int'(ov[1]);
    end
    chk("t6_no_ov", nov, 0);
    chk("t6_busy_idle", busy_w[0], 0);
    chk("t6_warm_idle", warm_w[1], 0);
    send(32'h0004_0000);
    chk("t6_first_mean", obs_mean[0], sx(32'h0001_0000));
    chk("t6_first_warm", obs_warm[0], 0);

    // random stream with occasional spikes
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      v = 32'h0003_0000 + {20'd0, r[11:0]} - 32'h0000_0800;
      if (r[31:29] == 3'd0) v = v + (r[28] ? 32'h0010_0000 : 32'hFFF0_0000);
      send(v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
